axi4_lite_interconnect_m1sn: RTL

//  Parametrised AXI4-Lite 1-master/N-slave crossbar; successor to the fixed 1x2 interconnect.

---
 rtl/axi4_lite_interconnect_m1sn.sv | 277 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/axi4_lite_interconnect_m1sn.sv
// rtl/axi4_lite_interconnect_m1sn.sv - AXI4-Lite 1-master/N-slave address-decoding interconnect
// One transaction in flight; unmapped accesses get DECERR, slaves that stay silent too long get SLVERR.
module axi4_lite_interconnect_m1sn #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SLAVES = 4,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_LOW  = '0,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_HIGH = '0,
    parameter int TIMEOUT = 256
) (
    input  logic                                 iCLK,
    input  logic                                 iRST,

    input  logic [ADDR_WIDTH-1:0]                m0_AWADDR,
    input  logic                                 m0_AWVALID,
    output logic                                 m0_AWREADY,
    input  logic [DATA_WIDTH-1:0]                m0_WDATA,
    input  logic [DATA_WIDTH/8-1:0]              m0_WSTRB,
    input  logic                                 m0_WVALID,
    output logic                                 m0_WREADY,
    output logic [1:0]                           m0_BRESP,
    output logic                                 m0_BVALID,
    input  logic                                 m0_BREADY,
    input  logic [ADDR_WIDTH-1:0]                m0_ARADDR,
    input  logic                                 m0_ARVALID,
    output logic                                 m0_ARREADY,
    output logic [DATA_WIDTH-1:0]                m0_RDATA,
    output logic [1:0]                           m0_RRESP,
    output logic                                 m0_RVALID,
    input  logic                                 m0_RREADY,

    output logic [NUM_SLAVES-1:0]                s_AWVALID,
    input  logic [NUM_SLAVES-1:0]                s_AWREADY,
    output logic [NUM_SLAVES*ADDR_WIDTH-1:0]     s_AWADDR,
    output logic [NUM_SLAVES-1:0]                s_WVALID,
    input  logic [NUM_SLAVES-1:0]                s_WREADY,
    output logic [NUM_SLAVES*DATA_WIDTH-1:0]     s_WDATA,
    output logic [NUM_SLAVES*DATA_WIDTH/8-1:0]   s_WSTRB,
    input  logic [NUM_SLAVES-1:0]                s_BVALID,
    output logic [NUM_SLAVES-1:0]                s_BREADY,
    input  logic [NUM_SLAVES*2-1:0]              s_BRESP,
    output logic [NUM_SLAVES-1:0]                s_ARVALID,
    input  logic [NUM_SLAVES-1:0]                s_ARREADY,
    output logic [NUM_SLAVES*ADDR_WIDTH-1:0]     s_ARADDR,
    input  logic [NUM_SLAVES-1:0]                s_RVALID,
    output logic [NUM_SLAVES-1:0]                s_RREADY,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0]     s_RDATA,
    input  logic [NUM_SLAVES*2-1:0]              s_RRESP
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int IDX_WIDTH  = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam logic [31:0] TO_LAST = (TIMEOUT > 0) ? 32'(TIMEOUT - 1) : 32'd0;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        IDLE, W_ISSUE, W_RESP, R_ISSUE, R_RESP, W_ERR, R_ERR
    } state_t;

    state_t                 state;
    logic [IDX_WIDTH-1:0]   idx;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [DATA_WIDTH-1:0]  wdata_q;
    logic [STRB_WIDTH-1:0]  wstrb_q;
    logic                   aw_pend;
    logic                   w_pend;
    logic                   ar_pend;
    logic [1:0]             err_resp;
    logic [31:0]            cnt;

    logic                   ar_accept;
    logic                   w_accept;
    logic                   timeout_hit;
    logic                   aw_done;
    logic                   w_done;

    logic [ADDR_WIDTH-1:0]  dec_addr;
    logic [ADDR_WIDTH-1:0]  dec_low;
    logic                   dec_hit;
    logic [IDX_WIDTH-1:0]   dec_idx;

    logic                   sel_awready;
    logic                   sel_wready;
    logic                   sel_bvalid;
    logic [1:0]             sel_bresp;
    logic                   sel_arready;
    logic                   sel_rvalid;
    logic [DATA_WIDTH-1:0]  sel_rdata;
    logic [1:0]             sel_rresp;

    // Read wins over write when both are presented in the same IDLE cycle.
    assign m0_ARREADY = (state == IDLE) & m0_ARVALID;
    assign m0_AWREADY = (state == IDLE) & ~m0_ARVALID & m0_AWVALID & m0_WVALID;
    assign m0_WREADY  = m0_AWREADY;
    assign ar_accept  = m0_ARREADY;
    assign w_accept   = m0_AWREADY;

    assign timeout_hit = (TIMEOUT != 0) && (cnt == TO_LAST);

    assign sel_awready = s_AWREADY[idx];
    assign sel_wready  = s_WREADY[idx];
    assign sel_bvalid  = s_BVALID[idx];
    assign sel_bresp   = s_BRESP[idx*2 +: 2];
    assign sel_arready = s_ARREADY[idx];
    assign sel_rvalid  = s_RVALID[idx];
    assign sel_rdata   = s_RDATA[idx*DATA_WIDTH +: DATA_WIDTH];
    assign sel_rresp   = s_RRESP[idx*2 +: 2];

    assign aw_done = ~aw_pend | sel_awready;
    assign w_done  = ~w_pend | sel_wready;

    // Descending scan so the lowest matching window is the one left standing.
    always_comb begin
        dec_addr = m0_ARVALID ? m0_ARADDR : m0_AWADDR;
        dec_hit  = 1'b0;
        dec_idx  = '0;
        dec_low  = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (dec_addr >= SLAVE_LOW[i*ADDR_WIDTH +: ADDR_WIDTH] &&
                dec_addr <= SLAVE_HIGH[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
                dec_hit = 1'b1;
                dec_idx = IDX_WIDTH'(i);
                dec_low = SLAVE_LOW[i*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state    <= IDLE;
            idx      <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            aw_pend  <= 1'b0;
            w_pend   <= 1'b0;
            ar_pend  <= 1'b0;
            err_resp <= 2'b00;
            cnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (ar_accept || w_accept) begin
                        addr_q <= dec_addr - dec_low;
                        idx    <= dec_idx;
                        if (w_accept) begin
                            wdata_q <= m0_WDATA;
                            wstrb_q <= m0_WSTRB;
                        end
                        if (!dec_hit) begin
                            err_resp <= RESP_DECERR;
                            state    <= ar_accept ? R_ERR : W_ERR;
                        end else if (ar_accept) begin
                            ar_pend <= 1'b1;
                            state   <= R_ISSUE;
                        end else begin
                            aw_pend <= 1'b1;
                            w_pend  <= 1'b1;
                            state   <= W_ISSUE;
                        end
                    end
                end
                W_ISSUE: begin
                    if (aw_done && w_done) begin
                        aw_pend <= 1'b0;
                        w_pend  <= 1'b0;
                        cnt     <= '0;
                        state   <= W_RESP;
                    end else if (timeout_hit) begin
                        aw_pend  <= 1'b0;
                        w_pend   <= 1'b0;
                        err_resp <= RESP_SLVERR;
                        state    <= W_ERR;
                    end else begin
                        if (sel_awready) aw_pend <= 1'b0;
                        if (sel_wready)  w_pend  <= 1'b0;
                        cnt <= cnt + 32'd1;
                    end
                end
                W_RESP: begin
                    if (sel_bvalid && m0_BREADY) begin
                        state <= IDLE;
                    end else if (timeout_hit) begin
                        err_resp <= RESP_SLVERR;
                        state    <= W_ERR;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                R_ISSUE: begin
                    if (sel_arready) begin
                        ar_pend <= 1'b0;
                        cnt     <= '0;
                        state   <= R_RESP;
                    end else if (timeout_hit) begin
                        ar_pend  <= 1'b0;
                        err_resp <= RESP_SLVERR;
                        state    <= R_ERR;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                R_RESP: begin
                    if (sel_rvalid && m0_RREADY) begin
                        state <= IDLE;
                    end else if (timeout_hit) begin
                        err_resp <= RESP_SLVERR;
                        state    <= R_ERR;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                W_ERR: begin
                    if (m0_BREADY) state <= IDLE;
                end
                R_ERR: begin
                    if (m0_RREADY) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Only the selected slave is driven, and only while its phase is live.
    always_comb begin
        s_AWVALID = '0;
        s_AWADDR  = '0;
        s_WVALID  = '0;
        s_WDATA   = '0;
        s_WSTRB   = '0;
        s_BREADY  = '0;
        s_ARVALID = '0;
        s_ARADDR  = '0;
        s_RREADY  = '0;
        m0_BVALID = 1'b0;
        m0_BRESP  = 2'b00;
        m0_RVALID = 1'b0;
        m0_RDATA  = '0;
        m0_RRESP  = 2'b00;
        case (state)
            W_ISSUE: begin
                s_AWVALID[idx] = aw_pend;
                s_WVALID[idx]  = w_pend;
                s_AWADDR[idx*ADDR_WIDTH +: ADDR_WIDTH] = addr_q;
                s_WDATA[idx*DATA_WIDTH +: DATA_WIDTH]  = wdata_q;
                s_WSTRB[idx*STRB_WIDTH +: STRB_WIDTH]  = wstrb_q;
            end
            W_RESP: begin
                s_BREADY[idx] = m0_BREADY;
                m0_BVALID     = sel_bvalid;
                m0_BRESP      = sel_bresp;
            end
            R_ISSUE: begin
                s_ARVALID[idx] = ar_pend;
                s_ARADDR[idx*ADDR_WIDTH +: ADDR_WIDTH] = addr_q;
            end
            R_RESP: begin
                s_RREADY[idx] = m0_RREADY;
                m0_RVALID     = sel_rvalid;
                m0_RDATA      = sel_rdata;
                m0_RRESP      = sel_rresp;
            end
            W_ERR: begin
                m0_BVALID = 1'b1;
                m0_BRESP  = err_resp;
            end
            R_ERR: begin
                m0_RVALID = 1'b1;
                m0_RRESP  = err_resp;
            end
            default: ;
        endcase
    end

endmodule
